// File: rtl/nn_layer_sequencer.sv
// Time-multiplexed fully-connected layer: one shared signed MAC walks every
// neuron in turn, addressing external weight/bias ROMs, and streams results out.
module nn_layer_sequencer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 10,
    parameter int IN_W  = 9,
    parameter int W_W   = 12,
    parameter int OUT_W = 17,
    parameter int SHIFT = 4,
    localparam int AW   = (N_OUT * N_IN > 1) ? $clog2(N_OUT * N_IN) : 1,
    localparam int IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [N_IN*IN_W-1:0]  i_in_data,
    output logic [AW-1:0]         o_w_addr,
    input  logic [W_W-1:0]        i_w_data,
    output logic [IW-1:0]         o_b_addr,
    input  logic [OUT_W-1:0]      i_b_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [OUT_W-1:0]      o_out_data,
    output logic [IW-1:0]         o_out_idx,
    output logic                  o_out_last,
    output logic                  o_busy
);
    localparam int JW     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PROD_W = IN_W + W_W;
    localparam int ACC_W  = IN_W + W_W + $clog2(N_IN) + 1;
    localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_OUT - 1);

    typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

    state_t                       r_state, w_state_nxt;
    logic [N_IN-1:0][IN_W-1:0]    r_in;
    logic [IW-1:0]                r_i;
    logic [JW-1:0]                r_j;
    logic signed [ACC_W-1:0]      r_acc;
    logic [OUT_W-1:0]             r_out_data;
    logic [IW-1:0]                r_out_idx;
    logic                         r_out_last;
    logic                         r_out_valid;

    logic signed [IN_W-1:0]       w_in_sel;
    logic signed [W_W-1:0]        w_wgt;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_sum;
    logic [OUT_W-1:0]             w_res;

    assign w_in_sel = r_in[r_j];
    assign w_wgt    = i_w_data;
    assign w_prod   = PROD_W'(w_in_sel) * PROD_W'(w_wgt);
    assign w_sum    = r_acc + ACC_W'(w_prod);
    // Arithmetic shift floors toward -inf; the bias add wraps at OUT_W bits.
    assign w_res    = OUT_W'(w_sum >>> SHIFT) + i_b_data;

    assign o_w_addr    = AW'(r_i * N_IN + r_j);
    assign o_b_addr    = r_i;
    assign o_in_ready  = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_idx   = r_out_idx;
    assign o_out_last  = r_out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_in_valid) w_state_nxt = MAC;
            MAC:     if (r_j == J_LAST) w_state_nxt = EMIT;
            EMIT:    if (i_out_ready) w_state_nxt = (r_i == I_LAST) ? IDLE : MAC;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in        <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_in  <= i_in_data;
                    r_i   <= '0;
                    r_j   <= '0;
                    r_acc <= '0;
                end
                MAC: if (r_j == J_LAST) begin
                    r_out_data  <= w_res;
                    r_out_idx   <= r_i;
                    r_out_last  <= (r_i == I_LAST);
                    r_out_valid <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_j   <= r_j + 1'b1;
                end
                // i/j stay put while stalled so the ROM addresses hold.
                EMIT: if (i_out_ready) begin
                    r_out_valid <= 1'b0;
                    if (r_i != I_LAST) begin
                        r_i   <= r_i + 1'b1;
                        r_j   <= '0;
                        r_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with default parameters and
// behavioural weight/bias ROMs driven from the DUT's addresses.
module tb_nn_layer_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_data = '0;
    logic [4:0]  w_addr;
    logic [11:0] w_data;
    logic [3:0]  b_addr;
    logic [16:0] b_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;

    logic [11:0] w_rom [20];
    logic [16:0] b_rom [10];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        w_data = '0;
        b_data = '0;
        if (w_addr < 5'd20) w_data = w_rom[w_addr];
        if (b_addr < 4'd10) b_data = b_rom[b_addr];
    end

    nn_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_w_addr(w_addr), .i_w_data(w_data),
        .o_b_addr(b_addr), .i_b_data(b_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_idx(out_idx), .o_out_last(out_last),
        .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rom(input logic [11:0] w0, input logic [11:0] w1, input bit bias_idx);
        for (int i = 0; i < 10; i++) begin
            w_rom[2*i]   = w0;
            w_rom[2*i+1] = w1;
            b_rom[i]     = bias_idx ? 17'(i) : 17'd0;
        end
    endtask

    // Returns at the negedge of the first MAC cycle (handshake edge + 1).
    task automatic start(input logic [17:0] d);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [16:0] base, input bit add_idx, input int first);
        int n = first;
        int guard = 0;
        while (n < 10 && guard < 200) begin
            if (out_valid) begin
                check({tag, "_data"}, 32'(out_data), 32'(base + (add_idx ? 17'(n) : 17'd0)));
                check({tag, "_idx"}, 32'(out_idx), 32'(n));
                check({tag, "_last"}, 32'(out_last), 32'(n == 9));
                n++;
            end
            @(negedge clk);
            guard++;
        end
        check({tag, "_count"}, 32'(n), 32'd10);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int guard;
        set_rom(12'd16, 12'd0, 1'b1);

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_b_addr", 32'(b_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic compute + throughput: out_data = 16 + i, valid every 3 cycles
        start({9'd0, 9'd16});
        for (int k = 1; k <= 31; k++) begin
            check("thr_valid", 32'(out_valid), 32'((k % 3 == 0) && k <= 30));
            check("thr_in_ready", 32'(in_ready), 32'(k == 31));
            if (k % 3 != 0 && k < 31) begin
                check("thr_w_addr", 32'(w_addr), 32'(2 * (k / 3) + ((k % 3 == 1) ? 0 : 1)));
                check("thr_b_addr", 32'(b_addr), 32'(k / 3));
            end
            if (out_valid) begin
                check("thr_data", 32'(out_data), 32'(16 + k / 3 - 1));
                check("thr_idx", 32'(out_idx), 32'(k / 3 - 1));
                check("thr_last", 32'(out_last), 32'(k == 30));
            end
            @(negedge clk);
        end

        // Floor truncation: -1 >>> 4 stays -1
        set_rom(12'd1, 12'd0, 1'b0);
        start({9'd0, 9'h1FF});
        collect("floor", 17'h1FFFF, 1'b0, 0);

        // Wrap: 2*(-256*-2048) = 2^20, >>>4 = 2^16 wraps to 17'h10000
        set_rom(12'h800, 12'h800, 1'b0);
        start({9'h100, 9'h100});
        collect("wrap", 17'h10000, 1'b0, 0);

        // Backpressure on neuron 3 with ignored in_valid pulses
        set_rom(12'd16, 12'd0, 1'b1);
        start({9'd0, 9'd16});
        guard = 0;
        while (!(out_valid && out_idx == 4'd3) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_reach_n3", 32'(out_valid && out_idx == 4'd3), 32'd1);
        out_ready = 1'b0;
        in_data   = {9'd0, 9'd32};
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'd19);
            check("bp_idx", 32'(out_idx), 32'd3);
            check("bp_w_addr", 32'(w_addr), 32'd7);
            check("bp_b_addr", 32'(b_addr), 32'd3);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_n4_w_addr", 32'(w_addr), 32'd8);
        check("bp_n4_b_addr", 32'(b_addr), 32'd4);
        collect("bp", 17'd16, 1'b1, 4);

        // Asynchronous reset during neuron 5 MAC
        start({9'd0, 9'd16});
        guard = 0;
        while (!(b_addr == 4'd5 && !out_valid && busy) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reach_n5", 32'(b_addr == 4'd5 && !out_valid && busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_idx", 32'(out_idx), 32'd0);
        check("arst_out_last", 32'(out_last), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_w_addr", 32'(w_addr), 32'd0);
        check("arst_b_addr", 32'(b_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start({9'd0, 9'd16});
        collect("post_rst", 17'd16, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
